dm_stream_loader: RTL and testbench

- Bulk-load stage directly upstream of the data memory (8K x 16, single-ported, read or write per cycle, samples on negedge clk).
- Accepts a byte stream (e.g. BMP pixel bytes from the UART/SPI receiver) and packs byte pairs into 16-bit words.
- Writes the words sequentially into data memory starting at a programmed base address.
- Arbitrates the single data-memory port against the CPU data port; the CPU is stalled on collision cycles.

---
 rtl/dm_stream_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_dm_stream_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_stream_loader.sv
// ---------------------------------------------------------------------------
// dm_stream_loader
//
// Bulk-load stage placed directly in front of the single-ported data memory.
// Incoming stream bytes (for example BMP pixel bytes from the UART/SPI
// receiver) are packed little-endian into 16-bit words. The words are written
// sequentially into data memory, starting at a programmed base address.
// The memory port is shared with the CPU data port. The loader takes the port
// for exactly one cycle per word (the WR state). The CPU is stalled only when
// it requests an access during that cycle.
//
// Optional feature (build macro DM_LOADER_CHKSUM_EN):
//   When defined, an extra output port `chksum` is added. It carries the
//   running modulo-2^16 sum of every word written during the current load.
//   When undefined, the port and its adder are absent.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start           one-cycle pulse, begins a load when idle
//   base_addr       first word address, sampled on an accepted start
//   num_words       number of words to write, sampled on an accepted start
//   in_data/in_vld  byte stream input
//   in_rdy          loader accepts a byte this cycle
//   cpu_addr/cpu_re/cpu_we/cpu_wrt_data
//                   CPU data-port request
//   cpu_stall       CPU request not granted this cycle, CPU holds it
//   dm_addr/dm_re/dm_we/dm_wrt_data
//                   data-memory port (memory samples on negedge clk)
//   busy            load in progress
//   done            one-cycle pulse when a load completes
//   chksum          (DM_LOADER_CHKSUM_EN only) running word sum
// ---------------------------------------------------------------------------
module dm_stream_loader #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  input  logic [7:0]        in_data,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wrt_data,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wrt_data,
  output logic              busy,
  output logic              done
`ifdef DM_LOADER_CHKSUM_EN
  ,
  output logic [15:0]       chksum
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q,  base_d;
  logic [ADDR_W-1:0] num_q,   num_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic [7:0]        lo_q,    lo_d;
  logic [7:0]        hi_q,    hi_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic [ADDR_W-1:0] cnt_inc;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] packed_word;
  logic              wr_phase;

  // The write address is derived only from registered state. It is therefore
  // settled well before the memory samples it on the negedge. Modulo
  // wrap-around comes for free from the ADDR_W-wide sum.
  assign cnt_inc     = cnt_q + ADDR_W'(1);
  assign wr_addr     = base_q + cnt_q;
  assign packed_word = {hi_q, lo_q};
  assign wr_phase    = (state_q == ST_WR);

  // Next-state logic for the load sequencer.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base_addr;
          num_d  = num_words;
          cnt_d  = '0;
          // A zero-length load completes immediately. Busy stays low so the
          // done pulse is never seen alongside a stale busy.
          if (num_words == '0) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            busy_d  = 1'b1;
            state_d = ST_LO;
          end
        end
      end

      ST_LO: begin
        if (in_vld) begin
          lo_d    = in_data;
          state_d = ST_HI;
        end
      end

      ST_HI: begin
        if (in_vld) begin
          hi_d    = in_data;
          state_d = ST_WR;
        end
      end

      ST_WR: begin
        cnt_d = cnt_inc;
        if (cnt_inc == num_q) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_LO;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Sequencer registers. Reset also clears the base address, so the internal
  // write address returns to zero, and any half-assembled word is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      num_q   <= '0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Memory port arbitration. The loader wins only in WR. Every other cycle
  // the CPU request passes straight through, including the odd re&we combo,
  // which the memory itself ignores.
  always_comb begin
    dm_addr     = cpu_addr;
    dm_re       = cpu_re;
    dm_we       = cpu_we;
    dm_wrt_data = cpu_wrt_data;
    cpu_stall   = 1'b0;
    if (wr_phase) begin
      dm_addr     = wr_addr;
      dm_re       = 1'b0;
      dm_we       = 1'b1;
      dm_wrt_data = packed_word;
      cpu_stall   = cpu_re | cpu_we;
    end
  end

  assign in_rdy = (state_q == ST_LO) || (state_q == ST_HI);
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef DM_LOADER_CHKSUM_EN
  logic [15:0] chksum_q, chksum_d;

  // The running sum restarts on an accepted start. It accumulates each word in
  // its WR cycle and then holds after done until the next start.
  always_comb begin
    chksum_d = chksum_q;
    if (state_q == ST_IDLE && start) begin
      chksum_d = '0;
    end else if (wr_phase) begin
      chksum_d = chksum_q + 16'(packed_word);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chksum_q <= '0;
    end else begin
      chksum_q <= chksum_d;
    end
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_dm_stream_loader.sv
// ---------------------------------------------------------------------------
// Testbench for dm_stream_loader.
// A negedge monitor pops expected writes from a scoreboard queue. The
// expected writes are pushed while bytes are driven. A table of CPU port
// vectors covers the idle pass-through mux. Hand-written sequences cover
// wrap, collision, gapped input, zero length and mid-load reset.
// ---------------------------------------------------------------------------
module tb_dm_stream_loader;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] num_words;
  logic [7:0]        in_data;
  logic              in_vld;
  logic              in_rdy;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_re;
  logic              cpu_we;
  logic [DATA_W-1:0] cpu_wrt_data;
  logic              cpu_stall;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_re;
  logic              dm_we;
  logic [DATA_W-1:0] dm_wrt_data;
  logic              busy;
  logic              done;
`ifdef DM_LOADER_CHKSUM_EN
  logic [15:0]       chksum;
`endif

  always #5 clk = ~clk;

  dm_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .in_data      (in_data),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .cpu_addr     (cpu_addr),
    .cpu_re       (cpu_re),
    .cpu_we       (cpu_we),
    .cpu_wrt_data (cpu_wrt_data),
    .cpu_stall    (cpu_stall),
    .dm_addr      (dm_addr),
    .dm_re        (dm_re),
    .dm_we        (dm_we),
    .dm_wrt_data  (dm_wrt_data),
    .busy         (busy),
    .done         (done)
`ifdef DM_LOADER_CHKSUM_EN
    ,
    .chksum       (chksum)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    logic [ADDR_W-1:0] ca;
    logic              re;
    logic              we;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] exp_addr;
    logic              exp_re;
    logic              exp_we;
    logic [DATA_W-1:0] exp_wd;
    logic              exp_stall;
  } vec_t;

  wr_t         expQ[$];
  logic [15:0] fixedQ[$];
  bit          colChk = 1'b0;
  int          compared = 0;
  int          mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor. Any loader write (dm_we without a CPU write) must
  // match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (dm_we && !cpu_we) begin
        wr_t e;
        checkOutput("wr_in_rdy_low", {31'd0, in_rdy}, 32'd0);
        if (expQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   dm_addr, dm_wrt_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("wr_addr", {19'd0, dm_addr}, {19'd0, e.addr});
          checkOutput("wr_data", {16'd0, dm_wrt_data}, {16'd0, e.data});
        end
        if (colChk) begin
          checkOutput("col_stall_wr", {31'd0, cpu_stall}, 32'd1);
          checkOutput("col_re_wr", {31'd0, dm_re}, 32'd0);
        end
      end else if (colChk) begin
        checkOutput("col_addr", {19'd0, dm_addr}, 32'h5);
        checkOutput("col_re", {31'd0, dm_re}, 32'd1);
        checkOutput("col_stall", {31'd0, cpu_stall}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until the loader takes it (bounded wait).
  task automatic pushByte(input logic [7:0] b);
    bit got;
    got = 1'b0;
    in_data = b;
    in_vld  = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = in_rdy;
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("[TB] FAIL byte_timeout: in_rdy got 0, expected 1");
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
  endtask

  task automatic startPulse(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] n);
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    tick();
    start = 1'b0;
  endtask

  // Run a complete load. A gapped load drops in_vld for `gap` cycles between
  // the two bytes and pulses a stray start during the first gap.
  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input int n, input int gap);
    logic [15:0] w;
    wr_t e;
    startPulse(b, ADDR_W'(n));
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (fixedQ.size() != 0) w = fixedQ.pop_front();
      else w = 16'($urandom);
      e.addr = ADDR_W'(b + ADDR_W'(i));
      e.data = w;
      expQ.push_back(e);
      pushByte(w[7:0]);
      for (int g = 0; g < gap; g++) begin
        if (i == 0 && g == 0) begin
          start     = 1'b1;
          base_addr = '0;
          num_words = 13'd7;
          tick();
          start = 1'b0;
        end else begin
          tick();
        end
      end
      pushByte(w[15:8]);
    end
    // Last byte just taken: this cycle is the final WR, the next shows done.
    @(negedge clk);
    @(negedge clk);
    checkOutput("done_pulse", {31'd0, done}, 32'd1);
    checkOutput("busy_at_done", {31'd0, busy}, 32'd0);
    checkOutput("queue_empty", expQ.size(), 32'd0);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    tick();
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = '{13'h0005, 1'b1, 1'b0, 16'hAAAA, 13'h0005, 1'b1, 1'b0, 16'hAAAA, 1'b0};
    vecs[1] = '{13'h1FFF, 1'b0, 1'b1, 16'hBEEF, 13'h1FFF, 1'b0, 1'b1, 16'hBEEF, 1'b0};
    vecs[2] = '{13'h0000, 1'b1, 1'b1, 16'h1234, 13'h0000, 1'b1, 1'b1, 16'h1234, 1'b0};
    vecs[3] = '{13'h0ABC, 1'b0, 1'b0, 16'h0000, 13'h0ABC, 1'b0, 1'b0, 16'h0000, 1'b0};

    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    in_data = '0; in_vld = 1'b0;
    cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wrt_data = '0;
    repeat (3) tick();
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_in_rdy", {31'd0, in_rdy}, 32'd0);
    rst = 1'b0;
    tick();
    $display("[TB] idle port pass-through vectors");

    for (int i = 0; i < 4; i++) begin
      cpu_addr = vecs[i].ca; cpu_re = vecs[i].re;
      cpu_we = vecs[i].we; cpu_wrt_data = vecs[i].wd;
      @(negedge clk);
      checkOutput("mux_addr", {19'd0, dm_addr}, {19'd0, vecs[i].exp_addr});
      checkOutput("mux_re", {31'd0, dm_re}, {31'd0, vecs[i].exp_re});
      checkOutput("mux_we", {31'd0, dm_we}, {31'd0, vecs[i].exp_we});
      checkOutput("mux_data", {16'd0, dm_wrt_data}, {16'd0, vecs[i].exp_wd});
      checkOutput("mux_stall", {31'd0, cpu_stall}, {31'd0, vecs[i].exp_stall});
      tick();
    end
    cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wrt_data = '0;

    $display("[TB] basic load");
    fixedQ.push_back(16'h1234);
    fixedQ.push_back(16'h5678);
    applyStimulus(13'h0100, 2, 0);
`ifdef DM_LOADER_CHKSUM_EN
    checkOutput("chksum_basic", {16'd0, chksum}, 32'h68AC);
`endif

    $display("[TB] wrap loads");
    applyStimulus(13'h1FFF, 2, 0);
    applyStimulus(13'd8190, 4, 0);

    $display("[TB] collision with held cpu read");
    cpu_addr = 13'h0005; cpu_re = 1'b1;
    tick();
    colChk = 1'b1;
    applyStimulus(13'h0040, 3, 0);
    colChk = 1'b0;
    cpu_re = 1'b0; cpu_addr = '0;
    tick();

    $display("[TB] gapped input with stray start");
    applyStimulus(13'h0800, 2, 2);

    $display("[TB] zero length");
    startPulse(13'h0123, 13'd0);
    checkOutput("zero_done", {31'd0, done}, 32'd1);
    checkOutput("zero_busy", {31'd0, busy}, 32'd0);
    tick();
    checkOutput("zero_done_clear", {31'd0, done}, 32'd0);

    $display("[TB] reset mid-load");
    begin
      wr_t e;
      logic [15:0] w0;
      w0 = 16'hC3A5;
      startPulse(13'h0200, 13'd4);
      e.addr = 13'h0200; e.data = w0;
      expQ.push_back(e);
      pushByte(w0[7:0]);
      pushByte(w0[15:8]);
      pushByte(8'h99);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_in_rdy", {31'd0, in_rdy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      repeat (6) tick();
      checkOutput("rst_queue_empty", expQ.size(), 32'd0);
    end
    fixedQ.push_back(16'h4E21);
    applyStimulus(13'h0300, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
